// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency memory port between instruction fetch
//            and load/store, with misalignment rejection and one-cycle acks.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_ack,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_check = 2'd1;
    localparam logic [1:0] c_st_busy  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    generate
        if (MEM_LAT < 1) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be >= 1");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_grant_data;
    logic              r_we;
    logic              r_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_misaligned;

    always_comb begin
        case (r_size)
            2'b01:   w_misaligned = r_addr[0];
            2'b10:   w_misaligned = |r_addr[1:0];
            2'b11:   w_misaligned = |r_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_grant_data <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_st_idle: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    // Data wins a tie; the held fetch is picked up on the next IDLE.
                    if (d_req) begin
                        r_grant_data <= 1'b1;
                        r_we         <= d_we;
                        r_size       <= d_size;
                        r_addr       <= d_addr;
                        r_wdata      <= d_wdata;
                    end else if (if_req) begin
                        r_grant_data <= 1'b0;
                        r_we         <= 1'b0;
                        r_size       <= 2'b10;
                        r_addr       <= if_addr;
                        r_wdata      <= '0;
                    end
                end
                c_st_check: begin
                    r_err <= w_misaligned;
                    r_cnt <= '0;
                end
                c_st_busy: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last && !r_we) begin
                        r_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        if_err    = 1'b0;
        if_rdata  = '0;
        d_ack     = 1'b0;
        d_err     = 1'b0;
        d_rdata   = '0;
        case (r_state)
            c_st_idle: begin
                if (d_req || if_req) begin
                    w_next = c_st_check;
                end
            end
            c_st_check: begin
                w_next = w_misaligned ? c_st_done : c_st_busy;
            end
            c_st_busy: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_size  = r_size;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (r_cnt == c_cnt_last) begin
                    w_next = c_st_done;
                end
            end
            default: begin
                w_next = c_st_idle;
                if (r_grant_data) begin
                    d_ack   = 1'b1;
                    d_err   = r_err;
                    d_rdata = r_rdata;
                end else begin
                    if_ack   = 1'b1;
                    if_err   = r_err;
                    if_rdata = r_rdata[31:0];
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter (MEM_LAT 2/1/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    // Memory model: fixed word at 0x100, otherwise {addr[31:0], ~addr[31:0]}.
    assign mem_rdata = (mem_addr == 64'h100) ? 64'h0000_0000_0050_0093
                                             : {mem_addr[31:0], ~mem_addr[31:0]};

    mem_port_arbiter #(.XLEN(64), .ADDR_W(64), .MEM_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Extra builds at MEM_LAT=1 (index 0) and MEM_LAT=4 (index 1), fetch only.
    logic        x_req    [2];
    logic [63:0] x_addr   [2];
    logic        x_ack    [2];
    logic [31:0] x_rdata  [2];
    logic        x_err    [2];
    logic        x_dack   [2];
    logic [63:0] x_drdata [2];
    logic        x_derr   [2];
    logic        x_en     [2];
    logic        x_we     [2];
    logic [1:0]  x_msize  [2];
    logic [63:0] x_maddr  [2];
    logic [63:0] x_mwdata [2];
    logic [63:0] x_mrdata [2];

    assign x_mrdata[0] = (x_maddr[0] == 64'h100) ? 64'h0000_0000_0050_0093 : 64'h0;
    assign x_mrdata[1] = (x_maddr[1] == 64'h100) ? 64'h0000_0000_0050_0093 : 64'h0;

    mem_port_arbiter #(.XLEN(64), .ADDR_W(64), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(x_req[0]), .if_addr(x_addr[0]), .if_ack(x_ack[0]), .if_rdata(x_rdata[0]), .if_err(x_err[0]),
        .d_req(1'b0), .d_we(1'b0), .d_size(2'b00), .d_addr(64'h0), .d_wdata(64'h0),
        .d_ack(x_dack[0]), .d_rdata(x_drdata[0]), .d_err(x_derr[0]),
        .mem_en(x_en[0]), .mem_we(x_we[0]), .mem_size(x_msize[0]), .mem_addr(x_maddr[0]),
        .mem_wdata(x_mwdata[0]), .mem_rdata(x_mrdata[0])
    );

    mem_port_arbiter #(.XLEN(64), .ADDR_W(64), .MEM_LAT(4)) u_lat4 (
        .clk(clk), .reset(reset),
        .if_req(x_req[1]), .if_addr(x_addr[1]), .if_ack(x_ack[1]), .if_rdata(x_rdata[1]), .if_err(x_err[1]),
        .d_req(1'b0), .d_we(1'b0), .d_size(2'b00), .d_addr(64'h0), .d_wdata(64'h0),
        .d_ack(x_dack[1]), .d_rdata(x_drdata[1]), .d_err(x_derr[1]),
        .mem_en(x_en[1]), .mem_we(x_we[1]), .mem_size(x_msize[1]), .mem_addr(x_maddr[1]),
        .mem_wdata(x_mwdata[1]), .mem_rdata(x_mrdata[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Steps cycles until an ack on the main DUT (bounded), recording memory-side activity.
    task automatic wait_ack(output int cyc, output int en_cnt, output int we_cnt,
                            output logic [63:0] maddr, output logic [63:0] mwdata,
                            output logic [1:0] msize, output logic got_if, output logic got_d);
        cyc = 0; en_cnt = 0; we_cnt = 0; maddr = '0; mwdata = '0; msize = 2'b00;
        got_if = 1'b0; got_d = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_en) begin
                en_cnt++;
                if (mem_we) we_cnt++;
                maddr  = mem_addr;
                mwdata = mem_wdata;
                msize  = mem_size;
            end
            if (if_ack || d_ack) begin
                got_if = if_ack;
                got_d  = d_ack;
                break;
            end
        end
    endtask

    int          cyc, en_cnt, we_cnt;
    logic [63:0] maddr, mwdata;
    logic [1:0]  msize;
    logic        got_if, got_d;

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
        x_req[0] = 1'b0; x_req[1] = 1'b0; x_addr[0] = '0; x_addr[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", {63'b0, mem_en}, 64'd0);
        check("rst_acks", {62'b0, if_ack, d_ack}, 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        reset = 1'b0;

        // 1: aligned fetch
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 64'h100;
        wait_ack(cyc, en_cnt, we_cnt, maddr, mwdata, msize, got_if, got_d);
        if_req = 1'b0;
        check("t1_if_ack", {62'b0, got_if, got_d}, 64'd2);
        check("t1_latency", 64'(cyc), 64'd4);
        check("t1_en_cycles", 64'(en_cnt), 64'd2);
        check("t1_rdata", {32'b0, if_rdata}, 64'h0050_0093);
        check("t1_err", {63'b0, if_err}, 64'd0);
        check("t1_maddr", maddr, 64'h100);
        check("t1_msize", {62'b0, msize}, 64'd2);
        @(posedge clk); #1;
        check("t1_ack_pulse", {62'b0, if_ack, d_ack}, 64'd0);

        // 2: simultaneous load and fetch; data first
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b11; d_addr = 64'h2000;
        if_req = 1'b1; if_addr = 64'h100;
        wait_ack(cyc, en_cnt, we_cnt, maddr, mwdata, msize, got_if, got_d);
        d_req = 1'b0;
        check("t2_d_first", {62'b0, got_if, got_d}, 64'd1);
        check("t2_d_latency", 64'(cyc), 64'd4);
        check("t2_d_rdata", d_rdata, 64'h0000_2000_FFFF_DFFF);
        check("t2_d_maddr", maddr, 64'h2000);
        wait_ack(cyc, en_cnt, we_cnt, maddr, mwdata, msize, got_if, got_d);
        if_req = 1'b0;
        check("t2_if_second", {62'b0, got_if, got_d}, 64'd2);
        check("t2_if_latency", 64'(cyc), 64'd5);
        check("t2_if_rdata", {32'b0, if_rdata}, 64'h0050_0093);

        // 3: store
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b11; d_addr = 64'h2008; d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        wait_ack(cyc, en_cnt, we_cnt, maddr, mwdata, msize, got_if, got_d);
        d_req = 1'b0; d_we = 1'b0;
        check("t3_d_ack", {62'b0, got_if, got_d}, 64'd1);
        check("t3_we_cycles", 64'(we_cnt), 64'd2);
        check("t3_wdata", mwdata, 64'hDEAD_BEEF_CAFE_F00D);
        check("t3_maddr", maddr, 64'h2008);
        check("t3_rdata_zero", d_rdata, 64'd0);
        check("t3_err", {63'b0, d_err}, 64'd0);

        // 4: misaligned word load and fetch; half at odd address; byte at odd address is fine
        @(posedge clk); #1;
        d_req = 1'b1; d_size = 2'b10; d_addr = 64'h2002;
        wait_ack(cyc, en_cnt, we_cnt, maddr, mwdata, msize, got_if, got_d);
        d_req = 1'b0;
        check("t4_d_latency", 64'(cyc), 64'd2);
        check("t4_d_err", {62'b0, d_ack, d_err}, 64'd3);
        check("t4_d_no_mem", 64'(en_cnt), 64'd0);
        check("t4_d_rdata", d_rdata, 64'd0);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 64'h102;
        wait_ack(cyc, en_cnt, we_cnt, maddr, mwdata, msize, got_if, got_d);
        if_req = 1'b0;
        check("t4_if_err", {61'b0, got_if, if_err, got_d}, 64'd6);
        check("t4_if_latency", 64'(cyc), 64'd2);
        check("t4_if_no_mem", 64'(en_cnt), 64'd0);
        @(posedge clk); #1;
        d_req = 1'b1; d_size = 2'b01; d_addr = 64'h2001;
        wait_ack(cyc, en_cnt, we_cnt, maddr, mwdata, msize, got_if, got_d);
        d_req = 1'b0;
        check("t4_half_err", {62'b0, d_ack, d_err}, 64'd3);
        @(posedge clk); #1;
        d_req = 1'b1; d_size = 2'b00; d_addr = 64'h2003;
        wait_ack(cyc, en_cnt, we_cnt, maddr, mwdata, msize, got_if, got_d);
        d_req = 1'b0;
        check("t4_byte_ok", {62'b0, d_ack, d_err}, 64'd2);
        check("t4_byte_rdata", d_rdata, 64'h0000_2003_FFFF_DFFC);
        check("t4_byte_latency", 64'(cyc), 64'd4);

        // 5: reset during first BUSY cycle
        @(posedge clk); #1;
        d_req = 1'b1; d_size = 2'b11; d_addr = 64'h2000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_busy", {63'b0, mem_en}, 64'd1);
        reset = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_abort_en", {63'b0, mem_en}, 64'd0);
        got_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (d_ack || if_ack) got_d = 1'b1;
            @(posedge clk); #1;
        end
        check("t5_no_ack", {63'b0, got_d}, 64'd0);
        if_req = 1'b1; if_addr = 64'h100;
        wait_ack(cyc, en_cnt, we_cnt, maddr, mwdata, msize, got_if, got_d);
        if_req = 1'b0;
        check("t5_recover_lat", 64'(cyc), 64'd4);
        check("t5_recover_rdata", {32'b0, if_rdata}, 64'h0050_0093);

        // 6: MEM_LAT=1 and MEM_LAT=4 builds
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            x_req[k] = 1'b1; x_addr[k] = 64'h100;
            cyc = 0; en_cnt = 0; got_if = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                cyc++;
                if (x_en[k]) en_cnt++;
                if (x_ack[k]) begin
                    got_if = 1'b1;
                    break;
                end
            end
            x_req[k] = 1'b0;
            check($sformatf("t6_ack_lat%0d", k), {63'b0, got_if}, 64'd1);
            check($sformatf("t6_latency_lat%0d", k), 64'(cyc), (k == 0) ? 64'd3 : 64'd6);
            check($sformatf("t6_en_lat%0d", k), 64'(en_cnt), (k == 0) ? 64'd1 : 64'd4);
            check($sformatf("t6_rdata_lat%0d", k), {32'b0, x_rdata[k]}, 64'h0050_0093);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
